// File: rtl/brent_kung_5bit_pkg.sv
// brent_kung_pkg: shared width, operand type and prefix-cell functions for the 5-bit Brent-Kung adder
package brent_kung_pkg;
  localparam int BK_WIDTH = 5;
  typedef logic [BK_WIDTH-1:0] bk_operand_t;
  function automatic logic bk_g(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction
  function automatic logic bk_p(input logic p_hi, input logic p_lo);
    return p_hi & p_lo;
  endfunction
endpackage

// File: rtl/brent_kung_5bit_prefix_cell.sv
// bk_prefix_cell: black prefix cell; leave p_out unloaded where only a gray cell is needed
module bk_prefix_cell
  import brent_kung_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);
  assign g_out = bk_g(g_hi, p_hi, g_lo);
  assign p_out = bk_p(p_hi, p_lo);
endmodule

// File: rtl/brent_kung_5bit.sv
// brent_kung_5bit: two-stage pipelined 5-bit Brent-Kung adder; optional carry-in via BRENT_KUNG_5BIT_CIN_EN
module brent_kung_5bit
  import brent_kung_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BK_WIDTH-1:0] a_in,
  input  logic [BK_WIDTH-1:0] b_in,
`ifdef BRENT_KUNG_5BIT_CIN_EN
  input  logic                cin,
`endif
  output logic [BK_WIDTH-1:0] sum_out,
  output logic                cout_out
);
  bk_operand_t a_q, b_q, sum_q, sum_d, g, p, c;
  logic cout_q, cout_d, c0, g10, p10, g32, p32, g30, p30, g20, p20, g40, p40, unused_p;
`ifdef BRENT_KUNG_5BIT_CIN_EN
  logic cin_q;
  // stage 1: carry-in travels with its operands
  always_ff @(posedge clk or negedge rst_n)
    cin_q <= !rst_n ? 1'b0 : cin;
  assign c0 = cin_q;
`else
  assign c0 = 1'b0;
`endif
  // stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {a_q, b_q} <= '0;
    else {a_q, b_q} <= {a_in, b_in};
  assign g = a_q & b_q;
  assign p = a_q ^ b_q;
  // up-sweep
  bk_prefix_cell u_10 (.g_hi(g[1]), .p_hi(p[1]), .g_lo(bk_g(g[0], p[0], c0)), .p_lo(p[0]), .g_out(g10), .p_out(p10));
  bk_prefix_cell u_32 (.g_hi(g[3]), .p_hi(p[3]), .g_lo(g[2]), .p_lo(p[2]), .g_out(g32), .p_out(p32));
  bk_prefix_cell u_30 (.g_hi(g32), .p_hi(p32), .g_lo(g10), .p_lo(p10), .g_out(g30), .p_out(p30));
  // down-sweep
  bk_prefix_cell u_20 (.g_hi(g[2]), .p_hi(p[2]), .g_lo(g10), .p_lo(p10), .g_out(g20), .p_out(p20));
  bk_prefix_cell u_40 (.g_hi(g[4]), .p_hi(p[4]), .g_lo(g30), .p_lo(p30), .g_out(g40), .p_out(p40));
  assign unused_p = ^{p20, p40};
  assign c = {g30, g20, g10, bk_g(g[0], p[0], c0), c0};
  assign sum_d = p ^ c;
  assign cout_d = g40;
  // stage 2: result register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cout_q, sum_q} <= '0;
    else {cout_q, sum_q} <= {cout_d, sum_d};
  assign sum_out = sum_q;
  assign cout_out = cout_q;
endmodule

// File: tb/tb_brent_kung_5bit.sv
// tb_brent_kung_5bit: table vectors, reset corners and exhaustive sweep against a queued golden a+b(+cin)
module tb_brent_kung_5bit;
  logic clk = 0, rst_n = 0, cin = 0;
  logic [4:0] a = 0, b = 0, sum_out;
  logic cout_out;
  int total = 0, bad = 0;
  logic [5:0] q[$];
  typedef struct {logic [4:0] a, b; logic ci; logic [4:0] s; logic co;} vec_t;
  vec_t tbl[5];
  brent_kung_5bit dut (
    .clk(clk), .rst_n(rst_n), .a_in(a), .b_in(b),
`ifdef BRENT_KUNG_5BIT_CIN_EN
    .cin(cin),
`endif
    .sum_out(sum_out), .cout_out(cout_out));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {cout,sum}=%b want %b", name, act, exp);
    end
  endtask
  task automatic cycle(input logic [4:0] ai, input logic [4:0] bi, input logic ci, input logic [5:0] exp);
    @(negedge clk);
    if (q.size() == 2) chk("pipe", {cout_out, sum_out}, q.pop_front());
    a = ai; b = bi; cin = ci;
    q.push_back(exp);
  endtask
  task automatic drain();
    while (q.size() != 0) begin
      @(negedge clk);
      chk("drain", {cout_out, sum_out}, q.pop_front());
    end
  endtask
  initial begin
    tbl[0] = '{5'b00001, 5'b00010, 1'b0, 5'b00011, 1'b0};
    tbl[1] = '{5'b00101, 5'b00011, 1'b0, 5'b01000, 1'b0};
    tbl[2] = '{5'b11111, 5'b00001, 1'b0, 5'b00000, 1'b1};
    tbl[3] = '{5'b10101, 5'b01010, 1'b0, 5'b11111, 1'b0};
    tbl[4] = '{5'b01111, 5'b00101, 1'b0, 5'b10100, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset_hold", {cout_out, sum_out}, 6'd0);
    rst_n = 1;
    for (int i = 0; i < 5; i++) cycle(tbl[i].a, tbl[i].b, tbl[i].ci, {tbl[i].co, tbl[i].s});
    drain();
    for (int i = 0; i < 3; i++) cycle(5'd31, 5'd31, 1'b0, 6'd62);
    #3 rst_n = 0;
    #1 chk("reset_async", {cout_out, sum_out}, 6'd0);
    q.delete();
    a = 5'd3; b = 5'd4; cin = 0;
    @(negedge clk);
    chk("reset_flush", {cout_out, sum_out}, 6'd0);
    rst_n = 1;
    @(posedge clk); #1 chk("release_edge1", {cout_out, sum_out}, 6'd0);
    @(posedge clk); #1 chk("release_edge2", {cout_out, sum_out}, 6'd7);
`ifdef BRENT_KUNG_5BIT_CIN_EN
    for (int ci = 0; ci < 2; ci++)
`else
    for (int ci = 0; ci < 1; ci++)
`endif
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++)
          cycle(5'(i), 5'(j), 1'(ci), 6'(i + j + ci));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
